// File: rtl/dram_addr_capture.sv
// Receive-side decoder for the VIC multiplexed DRAM address bus: rebuilds 14-bit access
// addresses and classifies RAS-only refresh cycles. Define ADDR_CHECK_EN to enable hi_err.
module dram_addr_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic [11:0] ado,
    output logic        acc_valid,
    output logic [13:0] acc_addr,
    output logic        ref_valid,
    output logic [7:0]  ref_row,
    output logic [15:0] ref_count,
    output logic        seq_err,
    output logic        proto_err,
    output logic        hi_err
);

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        COL
    } state_t;

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] ras_sync;
    logic [SYNC_STAGES-1:0] cas_sync;
    logic [11:0]            ado_pipe [SYNC_STAGES];
    logic                   ras_prev;
    logic                   cas_prev;
    logic [2:0]             warm;
    logic                   ras_s;
    logic                   cas_s;
    logic [11:0]            ado_d;
    logic                   armed;
    logic                   ras_fall;
    logic                   ras_rise;
    logic                   cas_fall;

    state_t                 state;
    logic [7:0]             row;
    logic [7:0]             prev_ref;
    logic                   first_ref;

    assign ras_s = ras_sync[SYNC_STAGES-1];
    assign cas_s = cas_sync[SYNC_STAGES-1];
    assign ado_d = ado_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            ras_sync <= '1;
            cas_sync <= '1;
            ras_prev <= 1'b1;
            cas_prev <= 1'b1;
            warm     <= '0;
        end else begin
            ras_sync <= {ras_sync[SYNC_STAGES-2:0], ras_n};
            cas_sync <= {cas_sync[SYNC_STAGES-2:0], cas_n};
            ras_prev <= ras_s;
            cas_prev <= cas_s;
            if (warm != WARM_DONE) begin
                warm <= warm + 3'd1;
            end
        end
    end

    // Bus delay matches the strobe synchronizer so row/column data line up with edges.
    always_ff @(posedge clk_dot4x) begin
        ado_pipe[0] <= ado;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ado_pipe[i] <= ado_pipe[i-1];
        end
    end

    // Edges are ignored until the synchronizer has been refilled from the pins after
    // reset, so a strobe already low at release is not mistaken for a falling edge.
    assign armed    = (warm == WARM_DONE);
    assign ras_fall = armed & ras_prev & ~ras_s;
    assign ras_rise = armed & ~ras_prev & ras_s;
    assign cas_fall = armed & cas_prev & ~cas_s;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            ref_valid <= 1'b0;
            acc_addr  <= 14'h3FFF;
            ref_row   <= 8'hFF;
            ref_count <= 16'h0000;
            seq_err   <= 1'b0;
            proto_err <= 1'b0;
            first_ref <= 1'b1;
        end else begin
            acc_valid <= 1'b0;
            ref_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ras_fall) begin
                        row   <= ado_d[7:0];
                        state <= ROW;
                    end else if (cas_fall) begin
                        proto_err <= 1'b1;
                    end
                end
                ROW: begin
                    if (cas_fall) begin
                        acc_addr  <= {ado_d[5:0], row};
                        acc_valid <= 1'b1;
                        state     <= ras_rise ? IDLE : COL;
                    end else if (ras_rise) begin
                        ref_row   <= row;
                        ref_valid <= 1'b1;
                        if (ref_count != 16'hFFFF) begin
                            ref_count <= ref_count + 16'd1;
                        end
                        if (!first_ref && (row != prev_ref - 8'd1)) begin
                            seq_err <= 1'b1;
                        end
                        first_ref <= 1'b0;
                        prev_ref  <= row;
                        state     <= IDLE;
                    end
                end
                COL: begin
                    if (ras_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDR_CHECK_EN
    // A11..A8 appear both on the dedicated lines and in the column byte.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            hi_err <= 1'b0;
        end else if ((state == ROW) && cas_fall && (ado_d[11:8] != ado_d[3:0])) begin
            hi_err <= 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = &{1'b0, ado_d[11:8]};
    assign hi_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dram_addr_capture.sv
// Self-checking bench for dram_addr_capture: vector table, corner sequences and a
// randomized run scored against a transaction-level model.
module tb_dram_addr_capture;

    localparam int S        = 2;
    localparam int OP_ACC   = 0;
    localparam int OP_REF   = 1;
    localparam int OP_STRAY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ras_n;
    logic        cas_n;
    logic [11:0] ado;
    logic        acc_valid;
    logic [13:0] acc_addr;
    logic        ref_valid;
    logic [7:0]  ref_row;
    logic [15:0] ref_count;
    logic        seq_err;
    logic        proto_err;
    logic        hi_err;

    dram_addr_capture #(.SYNC_STAGES(S)) dut (
        .clk_dot4x(clk),
        .rst(rst),
        .ras_n(ras_n),
        .cas_n(cas_n),
        .ado(ado),
        .acc_valid(acc_valid),
        .acc_addr(acc_addr),
        .ref_valid(ref_valid),
        .ref_row(ref_row),
        .ref_count(ref_count),
        .seq_err(seq_err),
        .proto_err(proto_err),
        .hi_err(hi_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          acc_cyc_q[$];
    logic [13:0] acc_addr_q[$];
    logic [7:0]  ref_row_q[$];
    int          acc_rd = 0;
    int          ref_rd = 0;

    // Pulse monitor: every sampled cycle with a valid high is logged.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (acc_valid) begin
                acc_cyc_q.push_back(cyc);
                acc_addr_q.push_back(acc_addr);
            end
            if (ref_valid) begin
                ref_row_q.push_back(ref_row);
            end
        end
    end

    // Transaction-level reference model.
    logic [13:0] m_addr;
    logic [7:0]  m_ref_row;
    int          m_ref_count;
    logic        m_seq;
    logic        m_proto;
    logic        m_hi;
    logic [7:0]  m_hist[$];

    task automatic model_reset();
        m_addr      = 14'h3FFF;
        m_ref_row   = 8'hFF;
        m_ref_count = 0;
        m_seq       = 1'b0;
        m_proto     = 1'b0;
        m_hi        = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_access(input logic [13:0] a, input logic [3:0] hi);
        m_addr = a;
`ifdef ADDR_CHECK_EN
        if (hi != a[11:8]) m_hi = 1'b1;
`else
        if (hi != a[11:8]) m_hi = m_hi;
`endif
    endtask

    task automatic model_refresh(input logic [7:0] r);
        logic [7:0] want;
        if (m_hist.size() > 0) begin
            want = m_hist[m_hist.size()-1] - 8'd1;
            if (r != want) m_seq = 1'b1;
        end
        m_hist.push_back(r);
        m_ref_row = r;
        if (m_ref_count < 65535) m_ref_count = m_ref_count + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pulses(input string tag, input int n_acc, input logic [13:0] a,
                                 input int n_ref, input logic [7:0] r);
        int na;
        int nr;
        na = acc_addr_q.size() - acc_rd;
        nr = ref_row_q.size() - ref_rd;
        chk($sformatf("%s acc_pulses", tag), 32'(na), 32'(n_acc));
        if (na == 1 && n_acc == 1) chk($sformatf("%s acc_addr_at_pulse", tag), 32'(acc_addr_q[acc_rd]), 32'(a));
        chk($sformatf("%s ref_pulses", tag), 32'(nr), 32'(n_ref));
        if (nr == 1 && n_ref == 1) chk($sformatf("%s ref_row_at_pulse", tag), 32'(ref_row_q[ref_rd]), 32'(r));
        acc_rd = acc_addr_q.size();
        ref_rd = ref_row_q.size();
    endtask

    task automatic check_regs(input string tag);
        chk($sformatf("%s acc_addr", tag), 32'(acc_addr), 32'(m_addr));
        chk($sformatf("%s ref_row", tag), 32'(ref_row), 32'(m_ref_row));
        chk($sformatf("%s ref_count", tag), 32'(ref_count), 32'(m_ref_count));
        chk($sformatf("%s seq_err", tag), 32'(seq_err), 32'(m_seq));
        chk($sformatf("%s proto_err", tag), 32'(proto_err), 32'(m_proto));
        chk($sformatf("%s hi_err", tag), 32'(hi_err), 32'(m_hi));
    endtask

    task automatic check_reset_values(input string tag);
        chk($sformatf("%s acc_valid", tag), 32'(acc_valid), 32'd0);
        chk($sformatf("%s ref_valid", tag), 32'(ref_valid), 32'd0);
        chk($sformatf("%s acc_addr", tag), 32'(acc_addr), 32'h3FFF);
        chk($sformatf("%s ref_row", tag), 32'(ref_row), 32'hFF);
        chk($sformatf("%s ref_count", tag), 32'(ref_count), 32'd0);
        chk($sformatf("%s seq_err", tag), 32'(seq_err), 32'd0);
        chk($sformatf("%s proto_err", tag), 32'(proto_err), 32'd0);
        chk($sformatf("%s hi_err", tag), 32'(hi_err), 32'd0);
    endtask

    // One access: RAS low, CAS low two clocks later, both high three clocks after that.
    // Consecutive calls put CAS falls exactly 8 clocks apart.
    task automatic do_access_raw(input logic [11:0] w_row, input logic [11:0] w_col, output int cas_at);
        @(negedge clk);
        ado   = w_row;
        ras_n = 1'b0;
        repeat (2) @(negedge clk);
        ado    = w_col;
        cas_n  = 1'b0;
        cas_at = cyc;
        repeat (3) @(negedge clk);
        ras_n = 1'b1;
        cas_n = 1'b1;
        ado   = 12'($urandom);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_access(input logic [13:0] a, input logic [3:0] hi, output int cas_at);
        do_access_raw({a[11:8], a[7:0]}, {hi, 2'b11, a[13:8]}, cas_at);
    endtask

    task automatic do_refresh(input logic [7:0] r);
        @(negedge clk);
        ado   = {4'h0, r};
        ras_n = 1'b0;
        repeat (3) @(negedge clk);
        ras_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_stray();
        @(negedge clk);
        cas_n = 1'b0;
        repeat (3) @(negedge clk);
        cas_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (S + 3) @(negedge clk);
    endtask

    typedef struct {
        int          op;
        logic [11:0] w_row;
        logic [11:0] w_col;
        logic [13:0] e_addr;
        logic [7:0]  e_row;
        logic [15:0] e_cnt;
        logic        e_seq;
        logic        e_proto;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cas_at;
        int c1;
        int c2;
        logic [13:0] a;
        logic [3:0]  hi;
        logic [7:0]  r;

        vecs[0]  = '{OP_ACC,   12'h734, 12'h7F7, 14'h3734, 8'hFF, 16'd0, 1'b0, 1'b0};
        vecs[1]  = '{OP_REF,   12'h003, 12'h000, 14'h3734, 8'h03, 16'd1, 1'b0, 1'b0};
        vecs[2]  = '{OP_REF,   12'h002, 12'h000, 14'h3734, 8'h02, 16'd2, 1'b0, 1'b0};
        vecs[3]  = '{OP_REF,   12'h001, 12'h000, 14'h3734, 8'h01, 16'd3, 1'b0, 1'b0};
        vecs[4]  = '{OP_REF,   12'h000, 12'h000, 14'h3734, 8'h00, 16'd4, 1'b0, 1'b0};
        vecs[5]  = '{OP_REF,   12'h0FF, 12'h000, 14'h3734, 8'hFF, 16'd5, 1'b0, 1'b0};
        vecs[6]  = '{OP_REF,   12'h010, 12'h000, 14'h3734, 8'h10, 16'd6, 1'b1, 1'b0};
        vecs[7]  = '{OP_STRAY, 12'h000, 12'h000, 14'h3734, 8'h10, 16'd6, 1'b1, 1'b1};
        vecs[8]  = '{OP_ACC,   12'hA5C, 12'hAEA, 14'h2A5C, 8'h10, 16'd6, 1'b1, 1'b1};
        vecs[9]  = '{OP_ACC,   12'h000, 12'h0C0, 14'h0000, 8'h10, 16'd6, 1'b1, 1'b1};
        vecs[10] = '{OP_ACC,   12'hFFF, 12'hFFF, 14'h3FFF, 8'h10, 16'd6, 1'b1, 1'b1};

        rst   = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        ado   = 12'h000;
        repeat (4) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();

        for (int i = 0; i < 11; i++) begin
            cas_at = 0;
            case (vecs[i].op)
                OP_ACC:  do_access_raw(vecs[i].w_row, vecs[i].w_col, cas_at);
                OP_REF:  do_refresh(vecs[i].w_row[7:0]);
                default: do_stray();
            endcase
            settle();
            if (vecs[i].op == OP_ACC && acc_cyc_q.size() > acc_rd)
                chk($sformatf("vec%0d acc_latency", i), 32'(acc_cyc_q[acc_rd] - cas_at), 32'(S + 1));
            expect_pulses($sformatf("vec%0d", i), (vecs[i].op == OP_ACC) ? 1 : 0, vecs[i].e_addr,
                          (vecs[i].op == OP_REF) ? 1 : 0, vecs[i].e_row);
            chk($sformatf("vec%0d acc_addr", i), 32'(acc_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d ref_row", i), 32'(ref_row), 32'(vecs[i].e_row));
            chk($sformatf("vec%0d ref_count", i), 32'(ref_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d seq_err", i), 32'(seq_err), 32'(vecs[i].e_seq));
            chk($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(vecs[i].e_proto));
            chk($sformatf("vec%0d hi_err", i), 32'(hi_err), 32'd0);
        end

        // Reset while in ROW, with RAS still held low after release.
        @(negedge clk);
        ado   = 12'h0AB;
        ras_n = 1'b0;
        repeat (S + 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (S + 4) @(negedge clk);
        ras_n = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        model_reset();
        expect_pulses("midrst", 0, 14'h0, 0, 8'h0);
        check_regs("midrst");

        do_access(14'h1234, 4'h2, cas_at);
        settle();
        model_access(14'h1234, 4'h2);
        expect_pulses("postrst", 1, 14'h1234, 0, 8'h0);
        check_regs("postrst");

        // Back-to-back accesses, CAS falls 8 clocks apart.
        do_access(14'h0000, 4'h0, c1);
        do_access(14'h3FFF, 4'hF, c2);
        settle();
        chk("b2b acc_pulses", 32'(acc_addr_q.size() - acc_rd), 32'd2);
        if (acc_addr_q.size() - acc_rd == 2) begin
            chk("b2b addr0", 32'(acc_addr_q[acc_rd]), 32'h0000);
            chk("b2b addr1", 32'(acc_addr_q[acc_rd+1]), 32'h3FFF);
            chk("b2b spacing", 32'(acc_cyc_q[acc_rd+1] - acc_cyc_q[acc_rd]), 32'(c2 - c1));
            chk("b2b cas_spacing", 32'(c2 - c1), 32'd8);
        end
        model_access(14'h0000, 4'h0);
        model_access(14'h3FFF, 4'hF);
        expect_pulses("b2b_done", 2, 14'h0, 0, 8'h0);
        check_regs("b2b");

        // RAS and CAS fall together in IDLE: row latched, CAS ignored, RAS rise is a refresh.
        @(negedge clk);
        ado   = 12'h05A;
        ras_n = 1'b0;
        cas_n = 1'b0;
        repeat (3) @(negedge clk);
        ado   = 12'h0C1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        repeat (2) @(negedge clk);
        settle();
        model_refresh(8'h5A);
        expect_pulses("simfall", 0, 14'h0, 1, 8'h5A);
        check_regs("simfall");

        // CAS fall together with RAS rise in ROW: access wins and FSM returns to IDLE.
        @(negedge clk);
        ado   = 12'h5C3;
        ras_n = 1'b0;
        repeat (3) @(negedge clk);
        ado   = 12'h5D5;
        cas_n = 1'b0;
        ras_n = 1'b1;
        repeat (3) @(negedge clk);
        cas_n = 1'b1;
        repeat (2) @(negedge clk);
        do_refresh(8'h59);
        settle();
        model_access(14'h15C3, 4'h5);
        model_refresh(8'h59);
        expect_pulses("simrise", 1, 14'h15C3, 1, 8'h59);
        check_regs("simrise");

        // High-line mismatch: dedicated lines 5, column byte says A11..A8 = 7.
        do_access(14'h3734, 4'h5, cas_at);
        settle();
        model_access(14'h3734, 4'h5);
        expect_pulses("hichk", 1, 14'h3734, 0, 8'h0);
        check_regs("hichk");

        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                a  = 14'($urandom);
                hi = ($urandom_range(0, 7) == 0) ? 4'($urandom) : a[11:8];
                do_access(a, hi, cas_at);
                settle();
                model_access(a, hi);
                expect_pulses($sformatf("rnd%0d", k), 1, a, 0, 8'h0);
            end else if (sel <= 8) begin
                r = ($urandom_range(0, 3) != 0) ? (m_ref_row - 8'd1) : 8'($urandom);
                do_refresh(r);
                settle();
                model_refresh(r);
                expect_pulses($sformatf("rnd%0d", k), 0, 14'h0, 1, r);
            end else begin
                do_stray();
                settle();
                m_proto = 1'b1;
                expect_pulses($sformatf("rnd%0d", k), 0, 14'h0, 0, 8'h0);
            end
            check_regs($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_addr_capture.md
# dram_addr_capture

Receive-side decoder for the VIC's multiplexed DRAM address bus. Watches `ras_n`/`cas_n` and the 12-bit address bus, latches the row and column phases, and rebuilds the full 14-bit VIC address for every access. RAS-only refresh cycles are classified separately, and their row is checked against the VIC's decrementing refresh counter. The block sits on the memory side of the bus, feeding the video RAM arbiter and the bus monitor.

## Interface
- `SYNC_STAGES`, 2: flops in the input synchronizer, legal range 2..3. `ado` is delayed by the same depth so that it stays aligned with the strobes.
- `clk_dot4x`  in  1  system clock; all logic sits on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ras_n`  in  1  row strobe, active low.
- `cas_n`  in  1  column strobe, active low.
- `ado`  in  12  address bus:
  - [7:0] carries A7..A0 in the row phase and {2'b11, A13..A8} in the column phase.
  - [11:8] always carries A11..A8, unmultiplexed.
- `acc_valid`  out  1  one-cycle pulse when an access address is ready.
- `acc_addr`  out  14  reconstructed address. Holds its value between pulses.
- `ref_valid`  out  1  one-cycle pulse when a refresh cycle completes.
- `ref_row`  out  8  row of the last refresh. Holds its value between pulses.
- `ref_count`  out  16  count of refresh cycles; saturates at 16'hFFFF.
- `seq_err`  out  1  sticky flag: refresh row was not the previous refresh row minus 1.
- `proto_err`  out  1  sticky flag: `cas_n` fell while `ras_n` was high.
- `hi_err`  out  1  sticky flag: high address lines mismatched. Only exists with `ADDR_CHECK_EN`.

## Operation
- Synchronized strobes are `ras_s` and `cas_s`; the delayed bus is `ado_d`.
- A falling edge is defined as previous synced value = 1 and current = 0.
- State machine has three states: `IDLE`, `ROW`, `COL`.
  - `IDLE` + `ras_s` falling: `row <= ado_d[7:0]`, go to `ROW`.
  - `ROW` + `cas_s` falling:
    - `acc_addr <= {ado_d[5:0], row}`.
    - Pulse `acc_valid`.
    - Go to `COL`.
    - `ado_d[7:6]` is ignored.
  - `ROW` + `ras_s` rising, no CAS seen (refresh):
    - `ref_row <= row` and pulse `ref_valid`.
    - Increment `ref_count`, saturating.
    - If this is not the first refresh since reset and `row != prev_ref - 8'd1` (mod 256, so 8'h00 follows 8'h01 and 8'hFF follows 8'h00), set `seq_err`.
    - `prev_ref <= row`; go to `IDLE`.
  - `COL` + `ras_s` rising: go to `IDLE`. A `cas_n` toggle while still in `COL` is ignored.
  - `cas_s` falling in `IDLE`: set `proto_err`; no access is emitted.
- Simultaneous `ras_s` and `cas_s` falling in `IDLE`:
  - Row is latched from `ado_d[7:0]`; go to `ROW`.
  - CAS is not treated as a column edge, because the column must arrive in a later cycle.
  - `proto_err` is not set.
- Simultaneous `cas_s` falling and `ras_s` rising in `ROW`: the access wins. Pulse `acc_valid`, then go to `IDLE` (not `COL`).
- Sticky flags clear only on `rst`.

## Timing
- Pin edge to internal edge detect: `SYNC_STAGES` clocks.
- `acc_valid` / `ref_valid` rise on the clock after edge detect, i.e. `SYNC_STAGES`+1 clocks after the pin edge. Each is high for exactly 1 clock.
- `acc_addr` / `ref_row` update in the same cycle that their valid pulse rises.
- Minimum strobe low/high width for reliable capture: 2 clocks.
- Reset values:
  - `acc_valid` = 0, `ref_valid` = 0.
  - `acc_addr` = 14'h3FFF, `ref_row` = 8'hFF, `ref_count` = 0.
  - All error flags = 0; state `IDLE`; first-refresh flag set.
  - Synchronizer flops reset to 1 (strobes idle).
- Reset asserted mid-access: the partial access is discarded and no pulse is emitted. After release, a strobe already held low does not produce a falling edge.

## Configuration
- `ADDR_CHECK_EN` defined:
  - At the column edge, compare `ado_d[11:8]` with `ado_d[3:0]` (A11..A8 as seen twice). On mismatch, set sticky `hi_err`.
  - `acc_addr` still uses the column-phase bits.
- `ADDR_CHECK_EN` not defined: `hi_err` is tied to 0 and the comparison logic is absent.

## Test plan
- Access: row phase `ado`=12'h734 (A7..A0 = 8'h34), then column phase `ado`=12'h7F7 (A13..A8 = 6'h37, A11..A8 = 4'h7) -> one `acc_valid` pulse, `acc_addr`=14'h3734, latency `SYNC_STAGES`+1 from the CAS fall.
- Refresh sequence: five RAS-only cycles with rows 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF -> five `ref_valid` pulses, `ref_count`=5, `seq_err`=0. A sixth refresh with row 8'h10 -> `seq_err`=1.
- CAS fall with RAS high -> `proto_err`=1, no `acc_valid`. Then a normal access -> correct `acc_addr`, `proto_err` stays 1.
- `ADDR_CHECK_EN`: column phase with `ado[11:8]`=4'h5 and `ado[3:0]`=4'h7 -> `hi_err`=1. Without the macro, `hi_err`=0.
- `rst` asserted while in `ROW` -> no pulse; all outputs return to reset values. The next full access decodes correctly.
- Back-to-back accesses 8 clocks apart with addresses 14'h0000 and 14'h3FFF -> two pulses carrying the exact addresses. `ref_count` is unchanged.
